// File: rtl/pulse_xfer_arbiter.sv
`default_nettype none
// ============================================================================
// pulse_xfer_arbiter -- round-robin sharing of one clka->clkb pulse channel
// Revision: 1.0
// ============================================================================
module pulse_xfer_arbiter #(
    parameter int N       = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 255
) (
    input  logic            clka,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic            xfer_ack,
    output logic            xfer_pulse,
    output logic [ID_W-1:0] xfer_id,
    output logic            busy,
    output logic [N-1:0]    pend,
    output logic [N-1:0]    done,
    output logic            timeout_err
);

    localparam int                c_cnt_w    = $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(TIMEOUT);
    localparam logic [ID_W-1:0]   c_last_rst = ID_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ID_W-1:0]     r_id;
    logic [ID_W-1:0]     r_last;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_cnt_w-1:0]  w_cnt_nxt;
    logic [N-1:0]        r_pend;
    logic [N-1:0]        r_done;
    logic                r_terr;
    logic [N-1:0]        w_done_nxt;
    logic                w_terr_nxt;
    logic [N-1:0]        w_clr;
    logic [N-1:0]        w_id_onehot;
    logic [ID_W-1:0]     w_win_hi;
    logic [ID_W-1:0]     w_win_lo;
    logic                w_any_hi;
    logic [ID_W-1:0]     w_winner;
    logic                w_grant;

    for (genvar i = 0; i < N; i++) begin : g_onehot
        assign w_id_onehot[i] = (r_id == ID_W'(i));
    end

    // Round robin: lowest pending index above last, else lowest pending overall.
    always_comb begin
        w_win_hi = '0;
        w_win_lo = '0;
        w_any_hi = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (r_pend[i]) begin
                w_win_lo = ID_W'(i);
                if (ID_W'(i) > r_last) begin
                    w_win_hi = ID_W'(i);
                    w_any_hi = 1'b1;
                end
            end
        end
        w_winner = w_any_hi ? w_win_hi : w_win_lo;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_done_nxt  = '0;
        w_terr_nxt  = 1'b0;
        w_clr       = '0;
        w_grant     = 1'b0;
        case (r_state)
            IDLE: begin
                // A stale high acknowledge from the far side must drain first.
                if (|r_pend && !xfer_ack) begin
                    w_state_nxt = ISSUE;
                    w_grant     = 1'b1;
                end
            end
            ISSUE: begin
                w_state_nxt = WAIT_HI;
                w_clr       = w_id_onehot;
            end
            WAIT_HI: begin
                if (xfer_ack) begin
                    w_state_nxt = WAIT_LO;
                end else if (r_cnt == c_cnt_max) begin
                    w_state_nxt = IDLE;
                    w_terr_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            WAIT_LO: begin
                if (!xfer_ack) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = w_id_onehot;
                end else if (r_cnt == c_cnt_max) begin
                    w_state_nxt = IDLE;
                    w_terr_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_id    <= '0;
            r_last  <= c_last_rst;
            r_cnt   <= '0;
            r_pend  <= '0;
            r_done  <= '0;
            r_terr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            // New request wins over the issue-cycle clear, re-queueing it.
            r_pend  <= (r_pend & ~w_clr) | req;
            r_done  <= w_done_nxt;
            r_terr  <= w_terr_nxt;
            if (w_grant) begin
                r_id   <= w_winner;
                r_last <= w_winner;
            end
        end
    end

    assign xfer_pulse  = (r_state == ISSUE);
    assign busy        = (r_state != IDLE);
    assign xfer_id     = r_id;
    assign pend        = r_pend;
    assign done        = r_done;
    assign timeout_err = r_terr;

endmodule
`default_nettype wire

// File: tb/tb_pulse_xfer_arbiter.sv
`default_nettype none
// ============================================================================
// tb_pulse_xfer_arbiter -- vector table, directed corner cases, random vs model
// Revision: 1.0
// ============================================================================
module tb_pulse_xfer_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic         clka = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req = '0;
    logic         ack = 1'b0;
    logic         xfer_pulse;
    logic [1:0]   xfer_id;
    logic         busy;
    logic [N-1:0] pend;
    logic [N-1:0] done;
    logic         timeout_err;

    int total = 0;
    int bad   = 0;

    pulse_xfer_arbiter #(.N(N), .ID_W(2), .TIMEOUT(TO)) dut (
        .clka        (clka),
        .rst_n       (rst_n),
        .req         (req),
        .xfer_ack    (ack),
        .xfer_pulse  (xfer_pulse),
        .xfer_id     (xfer_id),
        .busy        (busy),
        .pend        (pend),
        .done        (done),
        .timeout_err (timeout_err)
    );

    always #5 clka = ~clka;

    typedef struct {
        logic [3:0] rq;
        logic       ak;
        logic       b;
        logic       p;
        logic [1:0] id;
        logic [3:0] pd;
        logic [3:0] dn;
        logic       te;
    } vec_t;

    task automatic cyc();
        @(posedge clka);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [12:0] dut_out();
        return {busy, xfer_pulse, xfer_id, pend, done, timeout_err};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        ack   = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    // Waits for the grant, acks 3 cycles after the pulse, and checks done.
    task automatic serve(input int exp_id, input logic [3:0] exp_pend_after,
                         input logic [3:0] req_at_issue);
        int n;
        n = 0;
        while (!xfer_pulse && n < 40) begin
            cyc();
            n++;
        end
        chk("pulse_seen", xfer_pulse, 1);
        chk("grant_id", xfer_id, exp_id);
        req = req_at_issue;
        cyc();
        req = '0;
        chk("pend_after_issue", pend, exp_pend_after);
        cyc();
        cyc();
        ack = 1'b1;
        cyc();
        cyc();
        cyc();
        ack = 1'b0;
        n = 0;
        while (done == '0 && n < 10) begin
            cyc();
            n++;
        end
        chk("done_vec", done, 32'd1 << exp_id);
        chk("idle_at_done", busy, 0);
        cyc();
        chk("done_one_cycle", done, 0);
    endtask

    // Reference model: abstract phase (0 none, 1 pulsing, 2 awaiting rise,
    // 3 awaiting fall), pending set, last winner, and an age per phase.
    bit [3:0] m_pend;
    int       m_last, m_id, m_phase, m_age;
    bit [3:0] m_done;
    bit       m_terr;

    task automatic m_reset();
        m_pend = '0; m_last = N - 1; m_id = 0; m_phase = 0; m_age = 0;
        m_done = '0; m_terr = 1'b0;
    endtask

    function automatic logic [12:0] m_out();
        return {m_phase != 0, m_phase == 1, 2'(m_id), m_pend, m_done, m_terr};
    endfunction

    task automatic m_step(input bit [3:0] r, input bit a);
        bit [3:0] nd;
        bit       nt;
        bit       found;
        nd = '0;
        nt = 1'b0;
        case (m_phase)
            0: if (m_pend != 0 && !a) begin
                found = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    if (!found && m_pend[(m_last + k) % N]) begin
                        m_id  = (m_last + k) % N;
                        found = 1'b1;
                    end
                end
                m_last  = m_id;
                m_phase = 1;
            end
            1: begin
                m_pend[m_id] = 1'b0;
                m_phase = 2;
                m_age = 0;
            end
            2: if (a) begin
                m_phase = 3;
                m_age = 0;
            end else if (m_age >= TO) begin
                nt = 1'b1;
                m_phase = 0;
            end else m_age++;
            default: if (!a) begin
                nd[m_id] = 1'b1;
                m_phase = 0;
            end else if (m_age >= TO) begin
                nt = 1'b1;
                m_phase = 0;
            end else m_age++;
        endcase
        m_pend = m_pend | r;
        m_done = nd;
        m_terr = nt;
    endtask

    initial begin
        vec_t tbl[14];
        int   n, first;
        bit   flag;
        int   rise_at, fall_at;

        // Single request: ack high over t+6..t+11, low at t+12.
        tbl[0] = '{4'b0001, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0001, 4'b0000, 1'b0};
        tbl[1] = '{4'b0000, 1'b0, 1'b1, 1'b1, 2'd0, 4'b0001, 4'b0000, 1'b0};
        for (int k = 2; k <= 5; k++)
            tbl[k] = '{4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0};
        for (int k = 6; k <= 11; k++)
            tbl[k] = '{4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0};
        tbl[12] = '{4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0001, 1'b0};
        tbl[13] = '{4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0};

        do_reset();
        chk("reset_state", dut_out(), 13'h0);
        for (int k = 0; k < 14; k++) begin
            req = tbl[k].rq;
            ack = tbl[k].ak;
            cyc();
            chk($sformatf("vec%0d", k), dut_out(),
                {tbl[k].b, tbl[k].p, tbl[k].id, tbl[k].pd, tbl[k].dn, tbl[k].te});
        end
        req = '0;

        // Round robin from reset: grants 0,1,2,3.
        do_reset();
        req = 4'hF;
        cyc();
        req = '0;
        serve(0, 4'b1110, 4'b0000);
        serve(1, 4'b1100, 4'b0000);
        serve(2, 4'b1000, 4'b0000);
        serve(3, 4'b0000, 4'b0000);

        // Re-request of ID 2 in its own issue cycle.
        req = 4'b1100;
        cyc();
        req = '0;
        serve(2, 4'b1100, 4'b0100);
        serve(3, 4'b0100, 4'b0000);
        serve(2, 4'b0000, 4'b0000);

        // Timeout on ID 1 with ack held low; ID 3 queued meanwhile.
        req = 4'b0010;
        cyc();
        req = '0;
        n = 0;
        while (!xfer_pulse && n < 20) begin
            cyc();
            n++;
        end
        chk("to_grant_id", {xfer_pulse, xfer_id}, {1'b1, 2'd1});
        cyc();
        chk("to_wait_hi_busy", busy, 1);
        first = -1;
        flag  = 1'b0;
        for (int k = 1; k <= TO + 4 && first < 0; k++) begin
            req = (k == 2) ? 4'b1000 : 4'b0000;
            cyc();
            if (done != '0) flag = 1'b1;
            if (timeout_err && first < 0) first = k;
        end
        req = '0;
        chk("to_latency", first, TO + 1);
        chk("to_no_done", flag, 0);
        chk("to_idle_pend", {busy, done, pend}, {1'b0, 4'b0000, 4'b1000});
        cyc();
        chk("to_one_cycle", timeout_err, 0);
        serve(3, 4'b0000, 4'b0000);

        // Stale ack blocks issue; then reset during WAIT_LO.
        ack = 1'b1;
        req = 4'b0100;
        cyc();
        req = '0;
        flag = 1'b0;
        repeat (6) begin
            cyc();
            if (xfer_pulse || busy) flag = 1'b1;
        end
        chk("stale_blocks", flag, 0);
        chk("stale_pend", pend, 4'b0100);
        ack = 1'b0;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!xfer_pulse && n < 8);
        chk("stale_release_lat", n, 1);
        chk("stale_grant_id", xfer_id, 2);
        req = 4'b0001;
        cyc();
        req = '0;
        ack = 1'b1;
        cyc();
        chk("pre_reset", {busy, pend}, {1'b1, 4'b0001});
        rst_n = 1'b0;
        #1;
        chk("async_reset", dut_out(), 13'h0);
        ack = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        cyc();
        chk("post_reset_idle", dut_out(), 13'h0);

        // Random traffic against the reference model.
        do_reset();
        m_reset();
        rise_at = -1;
        fall_at = -1;
        for (int c = 0; c < 4000; c++) begin
            chk("rand_cycle", dut_out(), m_out());
            if ($urandom_range(0, 799) == 0) begin
                rst_n = 1'b0;
                req = '0;
                ack = 1'b0;
                #1;
                chk("rand_reset", dut_out(), 13'h0);
                m_reset();
                rise_at = -1;
                fall_at = -1;
                @(posedge clka);
                #1;
                rst_n = 1'b1;
                continue;
            end
            if (m_phase == 1) begin
                int mode;
                mode    = $urandom_range(0, 7);
                rise_at = c + $urandom_range(1, 6);
                fall_at = rise_at + $urandom_range(1, 6);
                if (mode == 0) begin
                    rise_at = c + 1000000;
                    fall_at = rise_at + 1;
                end else if (mode == 1) begin
                    fall_at = rise_at + TO + 4;
                end
            end
            ack = (c >= rise_at && c < fall_at);
            req = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'h0;
            @(posedge clka);
            m_step(req, ack);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
